// File: rtl/pe_strided_if.sv
// Data/handshake bundle between the GLB-side buses, the PE and the opsum sink.
interface pe_strided_if #(
    parameter int unsigned DATA_BITS = 32
);
    logic [DATA_BITS-1:0] ifmap;
    logic                 ifmap_valid;
    logic                 ifmap_ready;
    logic [DATA_BITS-1:0] filter;
    logic                 filter_valid;
    logic                 filter_ready;
    logic [DATA_BITS-1:0] ipsum;
    logic                 ipsum_valid;
    logic                 ipsum_ready;
    logic [DATA_BITS-1:0] opsum;
    logic                 opsum_valid;
    logic                 opsum_ready;

    // GLB / sink side
    modport master (
        output ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        input  ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );

    // PE side
    modport slave (
        input  ifmap, ifmap_valid, filter, filter_valid, ipsum, ipsum_valid, opsum_ready,
        output ifmap_ready, filter_ready, ipsum_ready, opsum, opsum_valid
    );
endinterface

// File: rtl/pe_strided.sv
// Row-stationary PE with stride, finite column count, optional ReLU and
// parametrised widths. One 8b x 8b MAC per cycle into a psum bank.
module pe_strided #(
    parameter int unsigned DATA_BITS       = 32,
    parameter int unsigned LANES           = 4,
    parameter int unsigned IFMAP_SPAD_LEN  = 12,
    parameter int unsigned FILTER_SPAD_LEN = 48,
    parameter int unsigned PSUM_SPAD_LEN   = 4,
    parameter int unsigned CONFIG_SIZE     = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PE_en,
    input  logic [CONFIG_SIZE-1:0] i_config,
    output logic                   busy,
    output logic                   done,
    pe_strided_if.slave            bus
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned FIDX_W = $clog2(FILTER_SPAD_LEN);
    localparam int unsigned IIDX_W = $clog2(IFMAP_SPAD_LEN);
    localparam int unsigned PIDX_W = $clog2(PSUM_SPAD_LEN);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LD_FILTER = 3'd1;
    localparam logic [2:0] S_LD_IFMAP  = 3'd2;
    localparam logic [2:0] S_LD_IPSUM  = 3'd3;
    localparam logic [2:0] S_CONV      = 3'd4;
    localparam logic [2:0] S_WR_OPSUM  = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]             state_q, state_d;
    logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;   // words received in the current load
    logic [CNT_W-1:0]       ptr_q, ptr_d;     // spad write pointer
    logic [CNT_W-1:0]       mac_q, mac_d;     // flat filter index during CONV
    logic [CNT_W-1:0]       j_q, j_d;         // ifmap index during CONV
    logic [CNT_W-1:0]       k_q, k_d;         // output channel / psum index
    logic [CNT_W-1:0]       col_q, col_d;
    logic                   win_shift;

    logic [7:0]           filter_spad_q [FILTER_SPAD_LEN];
    logic [7:0]           ifmap_spad_q  [IFMAP_SPAD_LEN];
    logic [DATA_BITS-1:0] psum_spad_q   [PSUM_SPAD_LEN];

    logic [CNT_W-1:0] q_raw, q_eff, p_eff, rs_eff, stride_eff, adv, cols_m1;
    logic [CNT_W-1:0] rsq, prs, prsq, shift_amt, keep_base, ifm_need;
    logic             relu_en;

    logic [7:0]           f_byte, i_byte;
    logic signed [15:0]   prod;
    logic [DATA_BITS-1:0] mac_ext, psum_rd;

    // Decode the latched config word into effective loop bounds
    always_comb begin
        q_raw      = CNT_W'(cfg_q[1:0]) + CNT_W'(1);
        q_eff      = (q_raw > CNT_W'(LANES)) ? CNT_W'(LANES) : q_raw;
        cols_m1    = CNT_W'(cfg_q[6:2]);
        p_eff      = CNT_W'(cfg_q[8:7]) + CNT_W'(1);
        relu_en    = cfg_q[9];
        rs_eff     = (cfg_q[11:10] == 2'd0) ? CNT_W'(1) : CNT_W'(cfg_q[11:10]);
        stride_eff = CNT_W'(cfg_q[13:12]) + CNT_W'(1);
        adv        = (stride_eff < rs_eff) ? stride_eff : rs_eff;
        rsq        = rs_eff * q_eff;
        prs        = p_eff * rs_eff;
        prsq       = p_eff * rsq;
        shift_amt  = adv * q_eff;
        keep_base  = (rs_eff - adv) * q_eff;
        ifm_need   = (col_q == '0) ? rs_eff : adv;
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        wcnt_d    = wcnt_q;
        ptr_d     = ptr_q;
        mac_d     = mac_q;
        j_d       = j_q;
        k_d       = k_q;
        col_d     = col_q;
        win_shift = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PE_en) begin
                    cfg_d   = i_config;
                    wcnt_d  = '0;
                    ptr_d   = '0;
                    mac_d   = '0;
                    j_d     = '0;
                    k_d     = '0;
                    col_d   = '0;
                    state_d = S_LD_FILTER;
                end
            end
            S_LD_FILTER: begin
                if (bus.filter_valid) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    ptr_d  = ptr_q + q_eff;
                    if (wcnt_q == prs - CNT_W'(1)) begin
                        wcnt_d  = '0;
                        ptr_d   = '0;
                        state_d = S_LD_IFMAP;
                    end
                end
            end
            S_LD_IFMAP: begin
                if (bus.ifmap_valid) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                    ptr_d  = ptr_q + q_eff;
                    if (wcnt_q == ifm_need - CNT_W'(1)) begin
                        wcnt_d  = '0;
                        k_d     = '0;
                        state_d = S_LD_IPSUM;
                    end
                end
            end
            S_LD_IPSUM: begin
                if (bus.ipsum_valid) begin
                    k_d = k_q + CNT_W'(1);
                    if (k_q == p_eff - CNT_W'(1)) begin
                        k_d     = '0;
                        mac_d   = '0;
                        j_d     = '0;
                        state_d = S_CONV;
                    end
                end
            end
            S_CONV: begin
                mac_d = mac_q + CNT_W'(1);
                if (j_q == rsq - CNT_W'(1)) begin
                    j_d = '0;
                    k_d = k_q + CNT_W'(1);
                end else begin
                    j_d = j_q + CNT_W'(1);
                end
                if (mac_q == prsq - CNT_W'(1)) begin
                    mac_d   = '0;
                    k_d     = '0;
                    state_d = S_WR_OPSUM;
                end
            end
            S_WR_OPSUM: begin
                if (bus.opsum_ready) begin
                    k_d = k_q + CNT_W'(1);
                    if (k_q == p_eff - CNT_W'(1)) begin
                        k_d = '0;
                        if (col_q == cols_m1) begin
                            state_d = S_DONE;
                        end else begin
                            col_d     = col_q + CNT_W'(1);
                            ptr_d     = keep_base;
                            win_shift = 1'b1;
                            state_d   = S_LD_IFMAP;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, config and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            wcnt_q  <= '0;
            ptr_q   <= '0;
            mac_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            wcnt_q  <= wcnt_d;
            ptr_q   <= ptr_d;
            mac_q   <= mac_d;
            j_q     <= j_d;
            k_q     <= k_d;
            col_q   <= col_d;
        end
    end

    // Filter spad: unpack the first q lanes of each word in arrival order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FILTER_SPAD_LEN); i++) filter_spad_q[i] <= '0;
        end else if (state_q == S_LD_FILTER && bus.filter_valid) begin
            for (int c = 0; c < int'(LANES); c++) begin
                if (CNT_W'(c) < q_eff)
                    filter_spad_q[FIDX_W'(ptr_q + CNT_W'(c))] <= bus.filter[8*c +: 8];
            end
        end
    end

    // Ifmap spad: append with zero-point flip, or slide the window between columns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(IFMAP_SPAD_LEN); i++) ifmap_spad_q[i] <= '0;
        end else if (state_q == S_LD_IFMAP && bus.ifmap_valid) begin
            for (int c = 0; c < int'(LANES); c++) begin
                if (CNT_W'(c) < q_eff)
                    ifmap_spad_q[IIDX_W'(ptr_q + CNT_W'(c))] <= bus.ifmap[8*c +: 8] ^ 8'h80;
            end
        end else if (win_shift) begin
            for (int i = 0; i < int'(IFMAP_SPAD_LEN); i++) begin
                if (CNT_W'(i) + shift_amt < rsq)
                    ifmap_spad_q[i] <= ifmap_spad_q[IIDX_W'(CNT_W'(i) + shift_amt)];
                else
                    ifmap_spad_q[i] <= '0;
            end
        end
    end

    // Signed 8x8 product, sign-extended to the psum width
    always_comb begin
        f_byte  = filter_spad_q[FIDX_W'(mac_q)];
        i_byte  = ifmap_spad_q[IIDX_W'(j_q)];
        prod    = 16'($signed(f_byte)) * 16'($signed(i_byte));
        mac_ext = {{(DATA_BITS-16){prod[15]}}, prod};
    end

    // Psum bank: preload from ipsum, then accumulate one MAC per CONV cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PSUM_SPAD_LEN); i++) psum_spad_q[i] <= '0;
        end else if (state_q == S_LD_IPSUM && bus.ipsum_valid) begin
            psum_spad_q[PIDX_W'(k_q)] <= bus.ipsum;
        end else if (state_q == S_CONV) begin
            psum_spad_q[PIDX_W'(k_q)] <= psum_spad_q[PIDX_W'(k_q)] + mac_ext;
        end
    end

    // Output mux with optional ReLU; zero outside WR_OPSUM
    always_comb begin
        psum_rd   = psum_spad_q[PIDX_W'(k_q)];
        bus.opsum = '0;
        if (state_q == S_WR_OPSUM && !(relu_en && psum_rd[DATA_BITS-1]))
            bus.opsum = psum_rd;
    end

    assign bus.filter_ready = (state_q == S_LD_FILTER);
    assign bus.ifmap_ready  = (state_q == S_LD_IFMAP);
    assign bus.ipsum_ready  = (state_q == S_LD_IPSUM);
    assign bus.opsum_valid  = (state_q == S_WR_OPSUM);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_pe_strided.sv
// Randomised bench for pe_strided against a column/window convolution model.
module tb_pe_strided;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned CFG_W     = 14;

    logic             clk, rst, PE_en, busy, done;
    logic [CFG_W-1:0] cfg_in;

    pe_strided_if #(.DATA_BITS(DATA_BITS)) bus ();

    pe_strided #(
        .DATA_BITS(32), .LANES(4), .IFMAP_SPAD_LEN(12), .FILTER_SPAD_LEN(48),
        .PSUM_SPAD_LEN(4), .CONFIG_SIZE(14)
    ) dut (
        .clk(clk), .rst(rst), .PE_en(PE_en), .i_config(cfg_in),
        .busy(busy), .done(done), .bus(bus)
    );

    int n_chk = 0, n_fail = 0;
    logic [31:0] filt_words[$], ifm_words[$], ips_words[$];
    logic [31:0] fq[$], iq[$], pq[$], exp_q[$], got_q[$], model_q[$];
    int n_ftx = 0, n_itx = 0, n_ptx = 0, conv_cyc = 0, done_cnt = 0;
    int vld_pct = 100, rdy_pct = 100, stall_left = 0;
    bit pe_noise = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic pin(input string name, input int idx, input logic [31:0] exp);
        if (idx < got_q.size()) chk(name, got_q[idx], exp);
        else chk({name, " (missing)"}, 32'hDEAD_BEEF, exp);
    endtask

    function automatic logic [13:0] mk_cfg(int p, int q, int rsf, int s, int cols, bit relu);
        return {2'(s - 1), 2'(rsf), relu, 2'(p - 1), 5'(cols - 1), 2'(q - 1)};
    endfunction

    task automatic decode(input logic [13:0] cfg, output int p, output int q, output int rs,
                          output int adv, output int cols, output bit relu);
        int stride;
        q = int'(cfg[1:0]) + 1; if (q > 4) q = 4;
        cols = int'(cfg[6:2]) + 1;
        p = int'(cfg[8:7]) + 1;
        relu = cfg[9];
        rs = int'(cfg[11:10]); if (rs == 0) rs = 1;
        stride = int'(cfg[13:12]) + 1;
        adv = (stride < rs) ? stride : rs;
    endtask

    // Reference: column n convolves stream words [n*adv, n*adv+rs) against the filter rows
    task automatic build_expect(input logic [13:0] cfg);
        int p, q, rs, adv, cols; bit relu;
        logic [31:0] acc, fw, iw;
        logic [7:0] b;
        byte fb; int ib;
        decode(cfg, p, q, rs, adv, cols, relu);
        for (int col = 0; col < cols; col++)
            for (int k = 0; k < p; k++) begin
                acc = ips_words[col*p + k];
                for (int r = 0; r < rs; r++) begin
                    fw = filt_words[k*rs + r];
                    iw = ifm_words[col*adv + r];
                    for (int c = 0; c < q; c++) begin
                        b  = fw[8*c +: 8]; fb = byte'(b);
                        b  = iw[8*c +: 8]; ib = int'(b) - 128;
                        acc = acc + 32'(int'(fb) * ib);
                    end
                end
                if (relu && acc[31]) acc = 32'd0;
                exp_q.push_back(acc);
            end
    endtask

    task automatic gen_random(input logic [13:0] cfg);
        int p, q, rs, adv, cols; bit relu;
        decode(cfg, p, q, rs, adv, cols, relu);
        filt_words.delete(); ifm_words.delete(); ips_words.delete();
        for (int i = 0; i < p*rs; i++) filt_words.push_back($urandom);
        for (int i = 0; i < rs + (cols-1)*adv; i++) ifm_words.push_back($urandom);
        for (int i = 0; i < cols*p; i++) ips_words.push_back($urandom);
    endtask

    task automatic start_job(input logic [13:0] cfg);
        fq = filt_words; iq = ifm_words; pq = ips_words;
        n_ftx = 0; n_itx = 0; n_ptx = 0; conv_cyc = 0;
        @(negedge clk); #2; cfg_in = cfg; PE_en = 1;
        @(negedge clk); #2; PE_en = 0; cfg_in = CFG_W'($urandom);
    endtask

    task automatic run_job(input logic [13:0] cfg, input string name);
        int p, q, rs, adv, cols, t, d0; bit relu;
        decode(cfg, p, q, rs, adv, cols, relu);
        exp_q.delete(); got_q.delete();
        build_expect(cfg);
        model_q = exp_q;
        d0 = done_cnt;
        start_job(cfg);
        t = 0;
        while (done_cnt == d0 && t < 20000) begin @(negedge clk); t++; end
        chk({name, " done seen"}, 32'(done_cnt != d0), 32'd1);
        #3;
        chk({name, " busy after done"}, 32'(busy), 32'd0);
        chk({name, " opsums left"}, 32'(exp_q.size()), 32'd0);
        chk({name, " filter words"}, 32'(n_ftx), 32'(p*rs));
        chk({name, " ifmap words"}, 32'(n_itx), 32'(rs + (cols-1)*adv));
        chk({name, " ipsum words"}, 32'(n_ptx), 32'(cols*p));
        chk({name, " mac cycles"}, 32'(conv_cyc), 32'(cols*p*rs*q));
        repeat (2) @(negedge clk);
        chk({name, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    // Source drivers: random valid, pop on the edge where valid&&ready will transfer
    initial begin
        bus.filter_valid = 0; bus.filter = '0;
        forever begin
            @(negedge clk);
            if (fq.size() > 0 && !rst && $urandom_range(0, 99) < vld_pct) begin
                bus.filter_valid = 1; bus.filter = fq[0];
            end else begin
                bus.filter_valid = 0; bus.filter = $urandom;
            end
            #1;
            if (bus.filter_valid && bus.filter_ready && fq.size() > 0) begin
                void'(fq.pop_front()); n_ftx++;
            end
        end
    end

    initial begin
        bus.ifmap_valid = 0; bus.ifmap = '0;
        forever begin
            @(negedge clk);
            if (iq.size() > 0 && !rst && $urandom_range(0, 99) < vld_pct) begin
                bus.ifmap_valid = 1; bus.ifmap = iq[0];
            end else begin
                bus.ifmap_valid = 0; bus.ifmap = $urandom;
            end
            #1;
            if (bus.ifmap_valid && bus.ifmap_ready && iq.size() > 0) begin
                void'(iq.pop_front()); n_itx++;
            end
        end
    end

    initial begin
        bus.ipsum_valid = 0; bus.ipsum = '0;
        forever begin
            @(negedge clk);
            if (pq.size() > 0 && !rst && $urandom_range(0, 99) < vld_pct) begin
                bus.ipsum_valid = 1; bus.ipsum = pq[0];
            end else begin
                bus.ipsum_valid = 0; bus.ipsum = $urandom;
            end
            #1;
            if (bus.ipsum_valid && bus.ipsum_ready && pq.size() > 0) begin
                void'(pq.pop_front()); n_ptx++;
            end
        end
    end

    // Compare process: opsum vs model on every transfer, stability while stalled
    initial begin
        bit hold_chk; logic [31:0] held;
        hold_chk = 0; held = '0;
        bus.opsum_ready = 0;
        forever begin
            @(negedge clk);
            if (stall_left > 0 && bus.opsum_valid) begin
                bus.opsum_ready = 0; stall_left--;
            end else begin
                bus.opsum_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            #1;
            if (hold_chk) begin
                chk("opsum_valid held while stalled", 32'(bus.opsum_valid), 32'd1);
                chk("opsum stable while stalled", bus.opsum, held);
            end
            if (bus.opsum_valid && bus.opsum_ready) begin
                if (exp_q.size() == 0) chk("unexpected opsum", bus.opsum, 32'hXXXX_XXXX);
                else chk("opsum", bus.opsum, exp_q.pop_front());
                got_q.push_back(bus.opsum);
            end
            hold_chk = bus.opsum_valid && !bus.opsum_ready && !rst;
            held = bus.opsum;
        end
    end

    // Monitor: MAC-only cycles and done pulse width
    initial begin
        bit prev_done;
        prev_done = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (busy && !bus.filter_ready && !bus.ifmap_ready && !bus.ipsum_ready &&
                    !bus.opsum_valid && !done) conv_cyc++;
                if (done) begin
                    done_cnt++;
                    chk("done single cycle", 32'(prev_done), 32'd0);
                end
                prev_done = done;
            end else begin
                prev_done = 0;
            end
        end
    end

    // Start requests while busy must be ignored
    initial begin
        PE_en = 0;
        forever begin
            @(negedge clk);
            if (pe_noise) begin
                #1;
                if (busy && !done) begin
                    PE_en = 1;
                    @(negedge clk); #1;
                    PE_en = 0;
                end
            end
        end
    end

    function automatic logic [31:0] out_vec();
        return {25'd0, bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready,
                bus.opsum_valid, busy, done, |bus.opsum};
    endfunction

    initial begin
        logic [13:0] cfg;
        int t;
        rst = 1; cfg_in = '0;
        repeat (3) @(negedge clk);
        #1 chk("outputs in reset", out_vec(), 32'd0);
        #1 rst = 0;
        @(negedge clk); #1 chk("outputs idle after reset", out_vec(), 32'd0);

        // p=1 q=1 rs=1: -3*5 + 10
        cfg = mk_cfg(1, 1, 1, 1, 1, 0);
        filt_words = '{32'h0000_00FD}; ifm_words = '{32'h0000_0085}; ips_words = '{32'd10};
        run_job(cfg, "t1");
        chk("t1 model", model_q[0], 32'hFFFF_FFFB);
        pin("t1 opsum", 0, 32'hFFFF_FFFB);

        run_job(mk_cfg(1, 1, 1, 1, 1, 1), "t1 relu");
        pin("t1 relu opsum", 0, 32'd0);

        // p=4 q=4 rs=3, all ones
        filt_words.delete(); ifm_words.delete(); ips_words.delete();
        for (int i = 0; i < 12; i++) filt_words.push_back(32'h0101_0101);
        for (int i = 0; i < 3; i++) ifm_words.push_back(32'h8181_8181);
        for (int i = 0; i < 4; i++) ips_words.push_back(32'd0);
        run_job(mk_cfg(4, 4, 3, 1, 1, 0), "t2");
        chk("t2 mac cycles", 32'(conv_cyc), 32'd48);
        for (int i = 0; i < 4; i++) pin("t2 opsum", i, 32'd12);

        // rs=3 sliding window, stride 1/2/4
        filt_words = '{32'd1, 32'd1, 32'd1};
        ifm_words  = '{32'h81, 32'h82, 32'h83, 32'h84, 32'h85};
        ips_words  = '{32'd0, 32'd0, 32'd0};
        run_job(mk_cfg(1, 1, 3, 1, 3, 0), "t3 s1");
        chk("t3 s1 model col2", model_q[2], 32'd12);
        chk("t3 s1 ifmap words", 32'(n_itx), 32'd5);
        pin("t3 s1 col0", 0, 32'd6); pin("t3 s1 col1", 1, 32'd9); pin("t3 s1 col2", 2, 32'd12);

        ips_words = '{32'd0, 32'd0};
        run_job(mk_cfg(1, 1, 3, 2, 2, 0), "t3 s2");
        pin("t3 s2 col0", 0, 32'd6); pin("t3 s2 col1", 1, 32'd12);

        ifm_words = '{32'h81, 32'h82, 32'h83, 32'h84, 32'h85, 32'h86};
        run_job(mk_cfg(1, 1, 3, 4, 2, 0), "t3 s4");
        chk("t3 s4 ifmap words", 32'(n_itx), 32'd6);
        pin("t3 s4 col1", 1, 32'd15);

        // Output stall and ignored starts while busy
        cfg = mk_cfg(2, 2, 2, 1, 3, 0);
        gen_random(cfg);
        stall_left = 5; pe_noise = 1;
        run_job(cfg, "stall");
        pe_noise = 0;
        chk("stall cycles consumed", 32'(stall_left), 32'd0);

        // Random configurations and handshakes
        for (int n = 0; n < 14; n++) begin
            cfg = 14'($urandom);
            if (n == 3) cfg[6:2] = 5'd31;
            else cfg[6:2] = 5'($urandom_range(0, 4));
            gen_random(cfg);
            vld_pct = $urandom_range(50, 100);
            rdy_pct = $urandom_range(50, 100);
            run_job(cfg, $sformatf("rand%0d", n));
        end
        vld_pct = 100; rdy_pct = 100;

        // Reset mid-CONV
        filt_words.delete(); ifm_words.delete(); ips_words.delete();
        for (int i = 0; i < 12; i++) filt_words.push_back($urandom);
        for (int i = 0; i < 3; i++) ifm_words.push_back($urandom);
        for (int i = 0; i < 4; i++) ips_words.push_back($urandom);
        exp_q.delete();
        start_job(mk_cfg(4, 4, 3, 1, 1, 0));
        t = 0;
        while (conv_cyc < 10 && t < 2000) begin @(negedge clk); t++; end
        chk("reached CONV before reset", 32'(conv_cyc >= 10), 32'd1);
        #2 rst = 1;
        fq.delete(); iq.delete(); pq.delete(); exp_q.delete();
        #1 chk("outputs right after async reset", out_vec(), 32'd0);
        @(negedge clk); #3 chk("outputs one cycle into reset", out_vec(), 32'd0);
        @(negedge clk); #2 rst = 0;
        repeat (2) @(negedge clk);
        #1 chk("idle after mid-run reset", out_vec(), 32'd0);

        filt_words = '{32'h0000_00FD}; ifm_words = '{32'h0000_0085}; ips_words = '{32'd10};
        run_job(mk_cfg(1, 1, 1, 1, 1, 0), "t1 after reset");
        pin("t1 after reset opsum", 0, 32'hFFFF_FFFB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_strided.md
Name: pe_strided

Overview:
- Parametrised successor to the row-stationary PE used in the PE array.
- Stores one filter row set, a sliding ifmap window and a psum bank, and computes p output-channel partial sums per output column using one 8b x 8b MAC per cycle.
- Adds configurable stride, a finite column count ending in a done pulse with return to IDLE, an optional ReLU on the last accumulation stage, and parametrised lane, spad and data widths.
- Sits in the PE array between the GLB-side ifmap/filter/ipsum buses and the opsum bus.

Parameters:
- DATA_BITS, 32, width of the ifmap/filter/ipsum/opsum buses; also the psum width.
- LANES, 4, 8-bit lanes per bus word; must equal DATA_BITS/8.
- IFMAP_SPAD_LEN, 12, ifmap spad entries; must be >= 3*LANES.
- FILTER_SPAD_LEN, 48, filter spad entries; must be >= 4*3*LANES.
- PSUM_SPAD_LEN, 4, psum spad entries; must be >= 4.
- CONFIG_SIZE, 14, config word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- PE_en  in  1  start; sampled only in IDLE.
- i_config  in  CONFIG_SIZE  configuration word, latched on start.
- ifmap, filter, ipsum  in  DATA_BITS  input data buses.
- ifmap_valid, filter_valid, ipsum_valid  in  1  input handshakes.
- opsum_ready  in  1  downstream ready.
- opsum  out  DATA_BITS  output partial sum.
- ifmap_ready, filter_ready, ipsum_ready, opsum_valid  out  1  handshakes.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last column is written.

Behaviour:
- Config fields: [1:0] q-1 (input channels; effective q = min(field+1, LANES)); [6:2] cols-1 (1..32 columns); [8:7] p-1 (output channels); [9] relu_en; [11:10] rs (filter taps, 1..3; 0 is treated as 1); [13:12] stride-1 (1..4).
- Start: in IDLE with PE_en=1, latch i_config, clear all counters, go to LD_FILTER. PE_en is ignored outside IDLE.
- Handshake: a transfer occurs on valid&&ready. Each ready is combinational from state: filter_ready in LD_FILTER, ifmap_ready in LD_IFMAP, ipsum_ready in LD_IPSUM. opsum_valid is high in WR_OPSUM.
- Lane unpacking: lane k is bits [8k+7:8k]; lanes 0..q-1 are stored and lanes q.. are dropped.
  - Filter bytes are signed int8.
  - Ifmap bytes are uint8 and are stored XOR 0x80, so they are signed with zero-point 128.
- LD_FILTER: p*rs words, p*rs*q entries, stored in arrival order at index (k*rs + r)*q + c. Then go to LD_IFMAP.
- LD_IFMAP: column 0 reads rs words. Each later column reads min(stride, rs) words appended after the retained entries. Then go to LD_IPSUM.
- LD_IPSUM: p words into psum[0..p-1]. Then go to CONV.
- CONV: for k in 0..p-1 and j in 0..rs*q-1, psum[k] += filter[k*rs*q+j] * ifmap[j]. This is exactly p*rs*q cycles, with a signed 16b product sign-extended. Accumulation wraps modulo 2^DATA_BITS and is not saturated. Then go to WR_OPSUM.
- WR_OPSUM: opsum = psum[idx], idx 0..p-1, advancing on each opsum_ready.
  - With relu_en, a negative psum is output as 0; the stored value is unchanged.
  - opsum must stay stable while valid && !ready.
  - After the p-th transfer: if column count == cols-1, go to DONE; otherwise shift the ifmap window and go to LD_IFMAP.
- Window shift: drop min(stride, rs)*q oldest entries and move the rest to index 0. If stride >= rs, no entries are retained. Vacated entries are zeroed.
- DONE: done=1 for exactly one cycle, then go to IDLE. Spads keep their contents until the next start.
- Latency per column: loads + p*rs*q MAC cycles + p output transfers. A MAC never stalls.
- Reset, at any time including mid-operation:
  - state is IDLE and all spads and counters are 0.
  - All ready/valid outputs, busy, done and opsum are 0.

Test Plan:
- p=1,q=1,rs=1,cols=1, filter 0x000000FD, ifmap 0x00000085, ipsum 10 -> opsum 0xFFFFFFFB (-5). The same run with relu_en=1 -> opsum 0. done pulses once, busy drops the following cycle.
- p=4,q=4,rs=3,cols=1, filter bytes all 0x01, ifmap bytes all 0x81, ipsum 0 -> 48 CONV cycles, then opsum 12 four times.
- p=1,q=1,rs=3,stride=1,cols=3, filter 1,1,1, ifmap stream 0x81..0x85 (values 1..5), ipsum 0 -> ifmap reads 3,1,1 words; opsums 6, 9, 12.
- Same as the previous case with stride=2, cols=2 -> ifmap reads 3,2 words; opsums 6, 12. With stride=4 the second column reads 3 fresh words.
- opsum_ready held low 5 cycles in WR_OPSUM -> opsum_valid stays 1, opsum is unchanged and no state advance; PE_en pulses during busy are ignored.
- rst asserted mid-CONV -> all outputs 0 the next cycle. A new start then completes test 1 correctly.
